nbit_alu_mc: RTL and testbench
==============================

NBIT_ALU_MC -- requirements
Module: nbit_alu_mc

Interface
REQ-001 Parameter: WIDTH, 8, operand/result width in bits; legal range 4..32.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-low.
REQ-004 Port: in_valid  input  1  operation request valid.
REQ-005 Port: in_ready  output  1  block can accept an operation.
REQ-006 Port: sel  input  4  opcode.
REQ-007 Port: A  input  WIDTH  operand A.
REQ-008 Port: B  input  WIDTH  operand B.
REQ-009 Port: out_valid  output  1  result valid.
REQ-010 Port: out_ready  input  1  consumer accepts result.
REQ-011 Port: F  output  WIDTH  registered result.
REQ-012 Port: z  output  1  zero flag, F == 0.
REQ-013 Port: c_out  output  1  carry/shift-out flag.
REQ-014 Port: over_flow  output  1  signed overflow flag.

Function
REQ-015 FSM states IDLE, MUL, DONE; in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-016 Accept when in_valid && in_ready: sel, A, B SHALL be captured; input changes after acceptance are ignored until the next acceptance.
REQ-017 Single-cycle opcodes: IDLE -> DONE; out_valid asserted on the cycle after acceptance.
REQ-018 Opcode 0010 (multiply): IDLE -> MUL; WIDTH shift-add iterations, one per cycle; then MUL -> DONE; out_valid asserted exactly WIDTH+1 cycles after acceptance.
REQ-019 DONE -> IDLE on out_valid && out_ready; F and flags SHALL remain stable while out_valid=1 && out_ready=0.
REQ-020 0000 add: F = A+B mod 2^WIDTH; c_out = carry out; over_flow = signed overflow.
REQ-021 0001 sub: F = A+~B+1; c_out = carry out (1 = no borrow); over_flow = signed overflow.
REQ-022 0010 mul: F = low WIDTH bits of unsigned A*B; c_out = 1 if any high WIDTH bits are nonzero; over_flow = 0.
REQ-023 0011 negate: F = -A (two's complement); c_out = 0; over_flow = 1 if A = 1 followed by WIDTH-1 zeros.
REQ-024 1000 AND, 1001 XOR, 1010 OR, 1011 NOT A: bitwise on A,B; c_out = 0, over_flow = 0.
REQ-025 1100 rotate right by 1 / 1101 rotate left by 1: c_out = bit moved across the end; over_flow = 0.
REQ-026 1110 logical shift right by 1 / 1111 logical shift left by 1: zero fill; c_out = bit shifted out; over_flow = 0.
REQ-027 Reserved opcodes 0100-0111: single-cycle; F = 0, z = 1, c_out = 0, over_flow = 0.
REQ-028 z SHALL be computed from the final F for every opcode, multiply included.

Reset
REQ-029 rst=0 at a clock edge: state -> IDLE; F = 0, z = 0, c_out = 0, over_flow = 0, out_valid = 0; in_ready = 1 on the first edge after rst returns to 1.
REQ-030 Reset in MUL or DONE SHALL abort the operation; the aborted result is never presented.
REQ-031 in_valid is ignored while rst=0.

Configuration
REQ-032 Macro ALU_MUL_EN defined: multiply logic and MUL state are built; 0010 behaves per REQ-018/REQ-022.
REQ-033 ALU_MUL_EN undefined: no MUL state or multiplier datapath; 0010 is treated as reserved per REQ-027.

Verification (WIDTH=8)
REQ-034 add A=3,B=2 -> F=5, z=0, c_out=0; A=200,B=100 -> F=44, c_out=1; A=127,B=1 -> F=128, over_flow=1.
REQ-035 sub A=3,B=3 -> F=0, z=1, c_out=1; A=2,B=3 -> F=255, c_out=0.
REQ-036 mul A=15,B=17 -> F=255, c_out=0, out_valid exactly 9 cycles after acceptance; A=16,B=16 -> F=0, z=1, c_out=1; without ALU_MUL_EN -> F=0, z=1, 1-cycle latency.
REQ-037 rotate right A=3 -> F=129, c_out=1; shift left A=128 -> F=0, z=1, c_out=1; negate A=128 -> F=128, over_flow=1.
REQ-038 out_ready held 0 for 3 cycles in DONE -> F/flags stable, in_ready=0, in_valid ignored; out_ready=1 -> IDLE on the next edge.
REQ-039 rst=0 on cycle 4 of a multiply -> outputs zero, out_valid never asserted for that operation; the next add 3+2 -> F=5.

Source files
------------

// File: rtl/nbit_alu_mc.sv
// nbit_alu_mc: handshaked ALU with registered result/flags; shift-add multiply built only when ALU_MUL_EN is defined
module nbit_alu_mc #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       sel,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] F,
   output logic             z,
   output logic             c_out,
   output logic             over_flow
);
`ifdef ALU_MUL_EN
   typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DONE = 2'd2} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`endif
   state_t state, nxt;
   logic accept, mul_go;
   logic [WIDTH-1:0] alu_f;
   logic alu_c, alu_v;
   logic [WIDTH:0] sum;
   assign in_ready  = state == IDLE;
   assign out_valid = state == DONE;
   assign accept    = in_valid && in_ready;
`ifdef ALU_MUL_EN
   localparam int CW = $clog2(WIDTH + 1);
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0] mcand;
   logic [CW-1:0] cnt;
   logic [WIDTH:0] psum;
   logic mul_last;
   assign mul_go   = accept && sel == 4'b0010;
   assign mul_last = cnt == CW'(WIDTH);
   assign psum     = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, prod[0] ? mcand : {WIDTH{1'b0}}};
`else
   assign mul_go = 1'b0;
`endif
   // state register; reset aborts any operation in flight
   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else state <= nxt;
   end
   // next-state: multiply detours through MUL, everything else goes straight to DONE
   always_comb begin
      nxt = state;
      case (state)
`ifdef ALU_MUL_EN
         IDLE: if (accept) nxt = mul_go ? MUL : DONE;
         MUL: if (mul_last) nxt = DONE;
`else
         IDLE: if (accept) nxt = DONE;
`endif
         DONE: if (out_ready) nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end
   // single-cycle result and flags straight from the request inputs; unlisted opcodes give zero
   always_comb begin
      alu_f = '0;
      alu_c = 1'b0;
      alu_v = 1'b0;
      sum = '0;
      case (sel)
         4'b0000: begin
            sum = {1'b0, A} + {1'b0, B};
            {alu_c, alu_f} = sum;
            alu_v = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
         end
         4'b0001: begin
            sum = {1'b0, A} + {1'b0, ~B} + (WIDTH+1)'(1);
            {alu_c, alu_f} = sum;
            alu_v = (A[WIDTH-1] != B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
         end
         4'b0011: begin
            alu_f = -A;
            alu_v = A == {1'b1, {(WIDTH-1){1'b0}}};
         end
         4'b1000: alu_f = A & B;
         4'b1001: alu_f = A ^ B;
         4'b1010: alu_f = A | B;
         4'b1011: alu_f = ~A;
         4'b1100: begin
            alu_f = {A[0], A[WIDTH-1:1]};
            alu_c = A[0];
         end
         4'b1101: begin
            alu_f = {A[WIDTH-2:0], A[WIDTH-1]};
            alu_c = A[WIDTH-1];
         end
         4'b1110: begin
            alu_f = {1'b0, A[WIDTH-1:1]};
            alu_c = A[0];
         end
         4'b1111: begin
            alu_f = {A[WIDTH-2:0], 1'b0};
            alu_c = A[WIDTH-1];
         end
         default: alu_f = '0;
      endcase
   end
   // result registers load on acceptance (or multiply completion) and hold otherwise
   always_ff @(posedge clk) begin
      if (!rst) begin
         F <= '0;
         z <= 1'b0;
         c_out <= 1'b0;
         over_flow <= 1'b0;
`ifdef ALU_MUL_EN
         prod <= '0;
         mcand <= '0;
         cnt <= '0;
`endif
      end else begin
         if (accept && !mul_go) begin
            F <= alu_f;
            z <= alu_f == '0;
            c_out <= alu_c;
            over_flow <= alu_v;
         end
`ifdef ALU_MUL_EN
         if (mul_go) begin
            mcand <= A;
            prod <= {{WIDTH{1'b0}}, B};
            cnt <= '0;
         end else if (state == MUL) begin
            if (mul_last) begin
               F <= prod[WIDTH-1:0];
               z <= prod[WIDTH-1:0] == '0;
               c_out <= |prod[2*WIDTH-1:WIDTH];
               over_flow <= 1'b0;
            end else begin
               prod <= {psum, prod[WIDTH-1:1]};
               cnt <= cnt + 1'b1;
            end
         end
`endif
      end
   end
endmodule

// File: tb/tb_nbit_alu_mc.sv
// tb_nbit_alu_mc: directed and randomized checks of nbit_alu_mc against an arithmetic reference model
module tb_nbit_alu_mc;
   localparam int W = 8;
   localparam longint M = (64'd1 << W) - 1;
   localparam longint H = 64'd1 << (W - 1);
`ifdef ALU_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif
   logic clk = 1'b0, rst = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [3:0] sel = '0;
   logic [W-1:0] A = '0, B = '0;
   logic in_ready, out_valid, z, c_out, over_flow;
   logic [W-1:0] F;
   int n_cmp = 0, n_bad = 0;

   nbit_alu_mc #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .sel(sel),
      .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready), .F(F), .z(z),
      .c_out(c_out), .over_flow(over_flow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int exp_lat(input logic [3:0] s);
      return (MUL_EN && s == 4'd2) ? W + 1 : 1;
   endfunction

   function automatic void model(input logic [3:0] s, input longint a, input longint b,
                                 output longint f, output bit c, output bit v);
      longint sa, sb, r;
      sa = (a >= H) ? a - (M + 1) : a;
      sb = (b >= H) ? b - (M + 1) : b;
      f = 0; c = 0; v = 0; r = 0;
      case (s)
         4'd0: begin r = a + b; f = r & M; c = r[W]; v = (sa + sb > H - 1) || (sa + sb < -H); end
         4'd1: begin r = a + ((~b) & M) + 1; f = r & M; c = r[W]; v = (sa - sb > H - 1) || (sa - sb < -H); end
         4'd2: if (MUL_EN) begin r = a * b; f = r & M; c = (r >> W) != 0; end
         4'd3: begin f = (M + 1 - a) & M; v = a == H; end
         4'd8: f = a & b;
         4'd9: f = a ^ b;
         4'd10: f = a | b;
         4'd11: f = (~a) & M;
         4'd12: begin f = (a >> 1) | ((a & 1) << (W - 1)); c = a[0]; end
         4'd13: begin f = ((a << 1) & M) | (a >> (W - 1)); c = a[W-1]; end
         4'd14: begin f = a >> 1; c = a[0]; end
         4'd15: begin f = (a << 1) & M; c = a[W-1]; end
         default: f = 0;
      endcase
   endfunction

   task automatic run_op(input logic [3:0] s, input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                         output logic [W-1:0] f, output logic zz, output logic cc, output logic vv, output int lat);
      @(negedge clk);
      check("in_ready_idle", in_ready, 1);
      in_valid = 1; sel = s; A = a; B = b;
      @(negedge clk);
      in_valid = 0; sel = 4'($urandom); A = W'($urandom); B = W'($urandom);
      lat = 1;
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      f = F; zz = z; cc = c_out; vv = over_flow;
      for (int i = 0; i < hold; i++) begin
         in_valid = 1; sel = 4'($urandom); A = W'($urandom); B = W'($urandom);
         @(negedge clk);
         check("hold_F", F, f);
         check("hold_flags", {z, c_out, over_flow}, {zz, cc, vv});
         check("hold_valid_ready", {out_valid, in_ready}, 2'b10);
      end
      in_valid = 0; out_ready = 1;
      @(negedge clk);
      out_ready = 0;
      check("release_idle", {in_ready, out_valid}, 2'b10);
   endtask

   task automatic directed(input logic [3:0] s, input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                           input logic [W-1:0] ef, input logic ez, input logic ec, input logic ev);
      logic [W-1:0] f;
      logic zz, cc, vv;
      int lat;
      run_op(s, a, b, hold, f, zz, cc, vv, lat);
      check($sformatf("dir_op%0h_%0d_%0d_F", s, a, b), f, ef);
      check($sformatf("dir_op%0h_%0d_%0d_zcv", s, a, b), {zz, cc, vv}, {ez, ec, ev});
      check($sformatf("dir_op%0h_lat", s), lat, exp_lat(s));
   endtask

   initial begin
      logic [W-1:0] f, ra, rb;
      logic zz, cc, vv, seen;
      logic [3:0] rs;
      longint mf;
      bit mc, mv;
      int lat, hold;
      repeat (3) @(negedge clk);
      check("reset_outputs", {F, z, c_out, over_flow, out_valid}, '0);
      rst = 1;
      @(negedge clk);
      check("reset_in_ready", in_ready, 1);

      directed(4'd0, 3, 2, 0, 5, 0, 0, 0);
      directed(4'd0, 200, 100, 0, 44, 0, 1, 0);
      directed(4'd0, 127, 1, 0, 128, 0, 0, 1);
      directed(4'd1, 3, 3, 0, 0, 1, 1, 0);
      directed(4'd1, 2, 3, 0, 255, 0, 0, 0);
      if (MUL_EN) begin
         directed(4'd2, 15, 17, 0, 255, 0, 0, 0);
         directed(4'd2, 16, 16, 0, 0, 1, 1, 0);
      end else begin
         directed(4'd2, 15, 17, 0, 0, 1, 0, 0);
         directed(4'd2, 16, 16, 0, 0, 1, 0, 0);
      end
      directed(4'd12, 3, 0, 0, 129, 0, 1, 0);
      directed(4'd15, 128, 0, 0, 0, 1, 1, 0);
      directed(4'd3, 128, 0, 0, 128, 0, 0, 1);
      directed(4'd5, 77, 9, 0, 0, 1, 0, 0);
      directed(4'd9, 8'hF0, 8'h3C, 3, 8'hCC, 0, 0, 0);

      @(negedge clk);
      in_valid = 1; sel = 4'd2; A = 15; B = 17;
      @(negedge clk);
      in_valid = 0;
      repeat (3) @(negedge clk);
      rst = 0; in_valid = 1; sel = 4'd0; A = 3; B = 2;
      repeat (2) @(negedge clk);
      check("abort_reset_outputs", {F, z, c_out, over_flow, out_valid}, '0);
      rst = 1; in_valid = 0;
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         seen |= out_valid;
      end
      check("abort_never_valid", seen, 0);
      directed(4'd0, 3, 2, 0, 5, 0, 0, 0);

      for (int n = 0; n < 150; n++) begin
         rs = 4'($urandom_range(15));
         ra = W'($urandom);
         rb = W'($urandom);
         if (n % 7 == 0) ra = (n % 2 == 0) ? W'(H) : W'(M);
         hold = ($urandom_range(3) == 0) ? int'($urandom_range(2, 1)) : 0;
         run_op(rs, ra, rb, hold, f, zz, cc, vv, lat);
         model(rs, longint'(ra), longint'(rb), mf, mc, mv);
         check($sformatf("rnd_op%0h_%0d_%0d_F", rs, ra, rb), f, mf);
         check($sformatf("rnd_op%0h_%0d_%0d_zcv", rs, ra, rb), {zz, cc, vv}, {mf == 0, mc, mv});
         check($sformatf("rnd_op%0h_lat", rs), lat, exp_lat(rs));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
